// File: rtl/instr_mem_ctrl_pkg.sv
// Shared types and constants for the instruction memory controller.
//   state_e     : fetch FSM state encoding
//   WORD_BYTES  : bytes per instruction word
//   ALIGN_MASK  : ALIGN_MODE value that silently clears addr[1:0]
//   ALIGN_FAULT : ALIGN_MODE value that faults on a misaligned address
//   CNT_W       : wait-state counter width (WAIT_STATES 0..15)
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES  = 4;
  localparam int ALIGN_MASK  = 0;
  localparam int ALIGN_FAULT = 1;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch and programming bus of the instruction memory controller.
//   req_valid/req_ready/req_addr : fetch request handshake (fetch stage -> memory)
//   rsp_valid/rsp_ready/rsp_data/rsp_fault : fetch response (memory -> fetch stage)
//   prog_we/prog_addr/prog_data  : byte programming port (loader -> memory)
// master: fetch stage + loader side; slave: memory controller side.
interface instr_mem_ctrl_if #(
  parameter int ADDR_W = 15
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;

  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );

endinterface

// File: rtl/instr_mem_ctrl_byte_ram.sv
// Byte-wide instruction storage.
//   clk       : clock
//   i_wr_en   : byte write enable (ignored when i_wr_addr >= DEPTH_BYTES)
//   i_wr_addr : byte write address
//   i_wr_data : byte write data
//   i_rd_en   : read strobe, loads the word register on the rising edge
//   i_rd_addr : byte address of the word to read (low two bits ignored)
//   o_rd_data : registered little-endian word {m[a+3],m[a+2],m[a+1],m[a]}
// Storage has no reset so a loaded program survives rst_n.
module instr_byte_ram
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DEPTH_BYTES = 2048
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data
);

  localparam int              IDX_W   = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  logic [7:0]       r_mem [DEPTH_BYTES];
  logic [31:0]      r_rd_data;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_unused_rd;

  assign w_wr_idx    = i_wr_addr[IDX_W-1:0];
  assign w_rd_idx    = {i_rd_addr[IDX_W-1:2], 2'b00};
  // Upper read-address bits are range-checked by the controller before a strobe.
  assign w_unused_rd = ^i_rd_addr;

  // Nonblocking update gives read-before-write when a write and a read
  // strobe hit the same byte on one edge.
  always_ff @(posedge clk) begin
    if (i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L)) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
    if (i_rd_en) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        r_rd_data[8*b +: 8] <= r_mem[w_rd_idx + IDX_W'(b)];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: single-outstanding fetch with optional
// read wait-states, alignment/range fault reporting and a byte program port.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (storage is not reset)
//   bus   : instr_mem_ctrl_if.slave (fetch request/response + programming)
//
// state | meaning
// IDLE  | ready for a request (req_ready=1 except first cycle after reset)
// WAIT  | request captured, counting WAIT_STATES cycles
// RESP  | rsp_valid=1, data/fault held until rsp_ready
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DEPTH_BYTES = 2048,
  parameter int WAIT_STATES = 0,
  parameter int ALIGN_MODE  = ALIGN_MASK
) (
  input logic              clk,
  input logic              rst_n,
  instr_mem_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W+1)'(DEPTH_BYTES - WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WAIT_STATES - 1);

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_fault;
  logic              r_ready;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_fault;
  logic              w_accept;
  logic              w_rd_en;
  logic [31:0]       w_rd_data;

  always_comb begin
    w_eff_addr = bus.req_addr;
    if (ALIGN_MODE == ALIGN_MASK) begin
      w_eff_addr[1:0] = 2'b00;
    end
  end

  assign w_fault = ((ALIGN_MODE == ALIGN_FAULT) && (bus.req_addr[1:0] != 2'b00)) ||
                   ({1'b0, w_eff_addr} > LAST_WORD);

  // r_ready is only ever set when the FSM is (or is about to be) in IDLE.
  assign w_accept = bus.req_valid && r_ready;

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_addr = r_addr;
    case (r_state)
      IDLE: begin
        w_rd_addr = w_eff_addr;
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_next = WAIT;
          end else begin
            w_next  = RESP;
            w_rd_en = !w_fault;
          end
        end
      end
      WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_next  = RESP;
          w_rd_en = !r_fault;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_fault <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      r_cnt   <= (r_state == WAIT) ? r_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_addr  <= w_eff_addr;
        r_fault <= w_fault;
      end
    end
  end

  instr_byte_ram #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (bus.prog_we),
    .i_wr_addr (bus.prog_addr),
    .i_wr_data (bus.prog_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // A faulted fetch never strobes the RAM, so its stale word is masked here.
  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_fault = (r_state == RESP) && r_fault;
  assign bus.rsp_data  = ((r_state == RESP) && !r_fault) ? w_rd_data : '0;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
module tb_instr_mem_ctrl;

  localparam int AW    = 15;
  localparam int DEPTH = 2048;

  typedef struct {
    int          d;
    logic [14:0] addr;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] mem_m [DEPTH];
  vec_t vecs [14];

  instr_mem_ctrl_if #(.ADDR_W(AW)) bus0 ();
  instr_mem_ctrl_if #(.ADDR_W(AW)) bus1 ();

  // d=0: no wait-states, address masking. d=1: 3 wait-states, misalign faults.
  instr_mem_ctrl #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .WAIT_STATES(0), .ALIGN_MODE(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_mem_ctrl #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .WAIT_STATES(3), .ALIGN_MODE(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: word at the effective address, or fault with zero data.
  function automatic void model(input int d, input logic [AW-1:0] a,
                                output logic [31:0] dat, output logic flt);
    int ea;
    ea  = (d == 1) ? int'(a) : (int'(a) / 4) * 4;
    flt = ((d == 1) && (int'(a) % 4 != 0)) || (ea > DEPTH - 4);
    dat = '0;
    if (!flt) dat = {mem_m[ea+3], mem_m[ea+2], mem_m[ea+1], mem_m[ea]};
  endfunction

  task automatic drv(input int d, input logic v, input logic [AW-1:0] a, input logic rr);
    if (d == 0) begin
      bus0.req_valid = v; bus0.req_addr = a; bus0.rsp_ready = rr;
    end else begin
      bus1.req_valid = v; bus1.req_addr = a; bus1.rsp_ready = rr;
    end
  endtask

  function automatic void smp(input int d, output logic rv, output logic rq,
                              output logic [31:0] dat, output logic flt);
    if (d == 0) begin
      rv = bus0.rsp_valid; rq = bus0.req_ready; dat = bus0.rsp_data; flt = bus0.rsp_fault;
    end else begin
      rv = bus1.rsp_valid; rq = bus1.req_ready; dat = bus1.rsp_data; flt = bus1.rsp_fault;
    end
  endfunction

  task automatic set_prog(input logic we, input logic [AW-1:0] a, input logic [7:0] v);
    bus0.prog_we = we; bus0.prog_addr = a; bus0.prog_data = v;
    bus1.prog_we = we; bus1.prog_addr = a; bus1.prog_data = v;
  endtask

  task automatic prog_byte(input logic [AW-1:0] a, input logic [7:0] v);
    @(negedge clk);
    set_prog(1'b1, a, v);
    @(posedge clk);
    #1 set_prog(1'b0, '0, '0);
    if (int'(a) < DEPTH) mem_m[int'(a)] = v;
  endtask

  task automatic wait_ready(input int d, input string nm);
    logic rv, rq, flt;
    logic [31:0] dat;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      smp(d, rv, rq, dat, flt);
      got = rq;
    end
    chk({nm, "_rdy"}, 32'(got), 32'd1);
  endtask

  task automatic fetch(input int d, input logic [AW-1:0] a, input int hold,
                       input logic [31:0] edat, input logic efl, input string nm);
    logic rv, rq, flt, fl0;
    logic [31:0] dat, dat0;
    int lat;
    bit got, bad;
    wait_ready(d, nm);
    drv(d, 1'b1, a, 1'b0);
    @(posedge clk);
    #1 drv(d, 1'b0, '0, 1'b0);
    got = 0; bad = 0; lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      lat++;
      smp(d, rv, rq, dat, flt);
      if (rq) bad = 1;
      got = rv;
    end
    chk({nm, "_lat"}, 32'(got ? lat : -1), 32'(ws_of(d) + 1));
    chk({nm, "_busy"}, 32'(bad), 32'd0);
    chk({nm, "_data"}, dat, edat);
    chk({nm, "_fault"}, 32'(flt), 32'(efl));
    dat0 = dat; fl0 = flt; bad = 0;
    for (int h = 0; h < hold; h++) begin
      drv(d, 1'b1, a + 15'd4, 1'b0);
      @(negedge clk);
      smp(d, rv, rq, dat, flt);
      if (!rv || rq || dat !== dat0 || flt !== fl0) bad = 1;
    end
    if (hold > 0) chk({nm, "_hold"}, 32'(bad), 32'd0);
    drv(d, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1 drv(d, 1'b0, '0, 1'b0);
    smp(d, rv, rq, dat, flt);
    chk({nm, "_done"}, 32'(rv), 32'd0);
  endtask

  initial begin
    logic rv, rq, flt;
    logic [31:0] dat, edat;
    logic efl;
    logic [AW-1:0] a;
    int d;
    bit bad;

    vecs[0]  = '{0, 15'd0,     0, 32'h0000011b, 1'b0};
    vecs[1]  = '{1, 15'd4,     0, 32'h0000019b, 1'b0};
    vecs[2]  = '{0, 15'd6,     0, 32'h0000019b, 1'b0};
    vecs[3]  = '{1, 15'd6,     0, 32'h00000000, 1'b1};
    vecs[4]  = '{0, 15'd2044,  0, 32'h00008067, 1'b0};
    vecs[5]  = '{1, 15'd2044,  2, 32'h00008067, 1'b0};
    vecs[6]  = '{0, 15'd2046,  0, 32'h00008067, 1'b0};
    vecs[7]  = '{0, 15'd2048,  1, 32'h00000000, 1'b1};
    vecs[8]  = '{1, 15'd2048,  0, 32'h00000000, 1'b1};
    vecs[9]  = '{0, 15'd12,    5, 32'h00a00513, 1'b0};
    vecs[10] = '{1, 15'd12,    5, 32'h00a00513, 1'b0};
    vecs[11] = '{0, 15'd15,    0, 32'h00a00513, 1'b0};
    vecs[12] = '{1, 15'd13,    3, 32'h00000000, 1'b1};
    vecs[13] = '{0, 15'd30000, 0, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    drv(0, 1'b0, '0, 1'b0);
    drv(1, 1'b0, '0, 1'b0);
    set_prog(1'b0, '0, '0);

    // Load the image while reset is held: writes work in any state.
    for (int i = 0; i < DEPTH; i++) prog_byte(AW'(i), 8'($urandom));
    prog_byte(15'd0, 8'h1b);    prog_byte(15'd1, 8'h01);    prog_byte(15'd2, 8'h00);    prog_byte(15'd3, 8'h00);
    prog_byte(15'd4, 8'h9b);    prog_byte(15'd5, 8'h01);    prog_byte(15'd6, 8'h00);    prog_byte(15'd7, 8'h00);
    prog_byte(15'd8, 8'h9b);    prog_byte(15'd9, 8'h02);    prog_byte(15'd10, 8'h00);   prog_byte(15'd11, 8'h00);
    prog_byte(15'd12, 8'h13);   prog_byte(15'd13, 8'h05);   prog_byte(15'd14, 8'ha0);   prog_byte(15'd15, 8'h00);
    prog_byte(15'd2044, 8'h67); prog_byte(15'd2045, 8'h80); prog_byte(15'd2046, 8'h00); prog_byte(15'd2047, 8'h00);

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      smp(k, rv, rq, dat, flt);
      chk($sformatf("rst%0d_req_ready", k), 32'(rq), 32'd0);
      chk($sformatf("rst%0d_rsp_valid", k), 32'(rv), 32'd0);
      chk($sformatf("rst%0d_rsp_data", k), dat, 32'd0);
      chk($sformatf("rst%0d_rsp_fault", k), 32'(flt), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      fetch(vecs[i].d, vecs[i].addr, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_fault,
            $sformatf("vec%0d", i));
    end

    // d0: write byte 8 on the accept edge, which is also the sample edge.
    wait_ready(0, "rbw0");
    drv(0, 1'b1, 15'd8, 1'b0);
    set_prog(1'b1, 15'd8, 8'haa);
    @(posedge clk);
    #1 drv(0, 1'b0, '0, 1'b0);
    set_prog(1'b0, '0, '0);
    mem_m[8] = 8'haa;
    @(negedge clk);
    smp(0, rv, rq, dat, flt);
    chk("rbw0_valid", 32'(rv), 32'd1);
    chk("rbw0_old", dat, 32'h0000029b);
    drv(0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1 drv(0, 1'b0, '0, 1'b0);
    fetch(0, 15'd8, 0, 32'h000002aa, 1'b0, "rbw0_new");

    // d1: write byte 16 on the edge that leaves WAIT and samples the RAM.
    model(1, 15'd16, edat, efl);
    wait_ready(1, "rbw1");
    drv(1, 1'b1, 15'd16, 1'b0);
    @(posedge clk);
    #1 drv(1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_prog(1'b1, 15'd16, 8'h3c);
    @(posedge clk);
    #1 set_prog(1'b0, '0, '0);
    @(negedge clk);
    smp(1, rv, rq, dat, flt);
    chk("rbw1_valid", 32'(rv), 32'd1);
    chk("rbw1_old", dat, edat);
    drv(1, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1 drv(1, 1'b0, '0, 1'b0);
    mem_m[16] = 8'h3c;
    model(1, 15'd16, edat, efl);
    fetch(1, 15'd16, 0, edat, efl, "rbw1_new");

    // Reset in the middle of a wait-state fetch; also program during reset.
    wait_ready(1, "rstw");
    drv(1, 1'b1, 15'd4, 1'b0);
    @(posedge clk);
    #1 drv(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    set_prog(1'b1, 15'd20, 8'h5c);
    @(posedge clk);
    #1 set_prog(1'b0, '0, '0);
    mem_m[20] = 8'h5c;
    @(negedge clk);
    smp(1, rv, rq, dat, flt);
    chk("rstw_valid", 32'(rv), 32'd0);
    chk("rstw_ready", 32'(rq), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      smp(1, rv, rq, dat, flt);
      if (rv) bad = 1;
    end
    chk("rstw_no_rsp", 32'(bad), 32'd0);
    fetch(1, 15'd4, 0, 32'h0000019b, 1'b0, "rstw_refetch");
    model(0, 15'd20, edat, efl);
    fetch(0, 15'd20, 0, edat, efl, "rstw_prog");

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) prog_byte(AW'($urandom_range(0, 2100)), 8'($urandom));
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = AW'($urandom_range(2036, 2060));
        1:       a = AW'($urandom);
        default: a = AW'($urandom_range(0, 2047));
      endcase
      model(d, a, edat, efl);
      fetch(d, a, int'($urandom_range(0, 3)), edat, efl, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
